// File: rtl/gf233_pkg.sv
// Shared constants and types for the GF(2^233) sequential reducer.
// Field polynomial f(x) = x^233 + x^74 + 1 (NIST B-233 trinomial).
// The 465-bit product is folded top-down in FOLD_W-bit windows.
// win_hi() and win_lo() return the bit range of window j.
package gf233_pkg;

    localparam int M      = 233;
    localparam int K      = 74;
    localparam int FOLD_W = 58;
    localparam int PROD_W = 2 * M - 1;
    localparam int N_FOLD = (M - 1 + FOLD_W - 1) / FOLD_W;
    localparam int CNT_W  = (N_FOLD > 1) ? $clog2(N_FOLD) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FOLD,
        DONE
    } state_e;

    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [M-1:0]      elem_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Top bit of fold window j.
    function automatic int win_hi(input int j);
        return PROD_W - 1 - j * FOLD_W;
    endfunction

    // Bottom bit of fold window j. The last window is clipped at x^M.
    function automatic int win_lo(input int j);
        int lo;
        lo = win_hi(j) - FOLD_W + 1;
        return (lo < M) ? M : lo;
    endfunction

endpackage

// File: rtl/gf233_reduce_seq_if.sv
// Handshake bundle for gf233_reduce_seq.
//   in_valid / in_ready / prod     : unreduced product from the multiplier
//   out_valid / out_ready / res    : reduced field element to the consumer
//   busy                           : reducer is not idle
// master = side that supplies products and takes results; slave = the reducer.
interface gf233_reduce_seq_if;

    logic                  in_valid;
    logic                  in_ready;
    gf233_pkg::prod_t      prod;
    logic                  out_valid;
    logic                  out_ready;
    gf233_pkg::elem_t      res;
    logic                  busy;

    modport master (
        output in_valid, prod, out_ready,
        input  in_ready, out_valid, res, busy
    );

    modport slave (
        input  in_valid, prod, out_ready,
        output in_ready, out_valid, res, busy
    );

endinterface

// File: rtl/gf233_fold_window.sv
// Combinational single-window fold for the B-233 reducer.
//   acc_i : partially reduced product
//   win_i : window index (0 = topmost window)
//   acc_o : acc_i with every set bit i of window win_i moved to
//           bits i-M and i-M+K (x^i = x^(i-M) * (x^K + 1) mod f)
// All targets lie below the window, so the bits of one window fold independently.
// An out-of-range index passes acc_i through unchanged.
module gf233_fold_window
    import gf233_pkg::*;
(
    input  prod_t acc_i,
    input  cnt_t  win_i,
    output prod_t acc_o
);

    function automatic prod_t fold_range(input prod_t a, input int lo, input int hi);
        prod_t r;
        r = a;
        for (int i = M; i < PROD_W; i++) begin
            if (i >= lo && i <= hi && a[i]) begin
                r[i]         = 1'b0;
                r[i - M]     = r[i - M] ^ 1'b1;
                r[i - M + K] = r[i - M + K] ^ 1'b1;
            end
        end
        return r;
    endfunction

    prod_t folded [N_FOLD];

    for (genvar j = 0; j < N_FOLD; j++) begin : g_win
        assign folded[j] = fold_range(acc_i, win_lo(j), win_hi(j));
    end

    always_comb begin
        // NOTE: acc_o gets a default before the selection loop so every path
        // assigns it and no latch is inferred.
        acc_o = acc_i;
        for (int j = 0; j < N_FOLD; j++) begin
            if (win_i == cnt_t'(j)) acc_o = folded[j];
        end
    end

endmodule

// File: rtl/gf233_reduce_seq.sv
// Sequential reduction of a 465-bit GF(2)[x] product modulo x^233 + x^74 + 1.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of gf233_reduce_seq_if (product in, result out)
// Accepts a product in IDLE, spends N_FOLD cycles folding one window per
// cycle, then holds the result in DONE until out_ready is seen.
module gf233_reduce_seq
    import gf233_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    gf233_reduce_seq_if.slave  bus
);

    state_e state_q, state_d;
    prod_t  acc_q,   acc_d;
    cnt_t   cnt_q,   cnt_d;
    elem_t  res_q,   res_d;

    prod_t  folded;
    logic   last_win;

    gf233_fold_window u_fold (
        .acc_i (acc_q),
        .win_i (cnt_q),
        .acc_o (folded)
    );

    assign last_win = (cnt_q == cnt_t'(N_FOLD - 1));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    acc_d   = bus.prod;
                    cnt_d   = '0;
                    state_d = FOLD;
                end
            end
            FOLD: begin
                acc_d = folded;
                cnt_d = cnt_q + cnt_t'(1);
                if (last_win) begin
                    res_d   = folded[M-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: acc is a single wide register, not a memory array, so it takes the
    // asynchronous reset like the rest of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            // Top-down folding must leave nothing at or above x^M.
            if (state_q == FOLD && last_win) begin
                assert (folded[PROD_W-1:M] == '0);
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.res       = res_q;

endmodule

// File: doc/gf233_reduce_seq.md
Name: gf233_reduce_seq

Overview:
- Downstream of the 233-bit odd-even Karatsuba multiplier (OKA_233bit → OKA_59bit → OKA_30bit tree).
- Takes the raw 465-bit GF(2)[x] product and reduces it modulo the NIST B-233 trinomial f(x) = x^233 + x^74 + 1.
- Returns a 233-bit field element.
- Folds the upper part a fixed window per cycle, trading latency for area.
- Uses a valid/ready handshake on both sides so it can sit between the combinational multiplier and a sequential point-arithmetic controller.

Parameters:
- M, 233, field degree.
- K, 74, middle trinomial exponent. Must satisfy 0 < K < M.
- FOLD_W, 58, upper-product bits folded per cycle. Must satisfy 1 ≤ FOLD_W ≤ M−K.
- Derived: PROD_W = 2M−1 = 465. N_FOLD = ceil((M−1)/FOLD_W) = 4.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: prod is valid.
- in_ready, output, 1: block can accept prod.
- prod, input, PROD_W: unreduced product. Bit i is the coefficient of x^i.
- out_valid, output, 1: res is valid.
- out_ready, input, 1: consumer accepts res.
- res, output, M: reduced product. Degree is at most M−1.
- busy, output, 1: state is not IDLE.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values:
  - state = IDLE; acc = 0; cnt = 0; res = 0.
  - out_valid = 0; busy = 0.
  - in_ready = 1 once rst_n is deasserted.
- FSM states: IDLE, FOLD, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready: acc ← prod, cnt ← 0, go to FOLD.
- FOLD:
  - in_ready = 0. in_valid is ignored.
  - Each edge folds window j = cnt. The window covers acc bits hi_j = PROD_W−1−j·FOLD_W down to lo_j = max(M, hi_j−FOLD_W+1).
  - For each set bit i in the window: clear bit i, XOR 1 into bit i−M, XOR 1 into bit i−M+K.
  - In the same edge, cnt ← cnt+1.
  - After the window with cnt = N_FOLD−1: res ← folded acc[M−1:0], go to DONE.
  - Windows are processed top-down. Each target i−M+K lies below lo_j, guaranteed by FOLD_W ≤ M−K, so no bit is lost. After the final window, acc[PROD_W−1:M] = 0; the implementation asserts this in simulation.
  - Default windows: 464..407, 406..349, 348..291, 290..233.
- DONE:
  - out_valid = 1.
  - res and out_valid stay stable until out_ready.
  - On an edge with out_ready: out_valid ← 0, go to IDLE.
  - No direct DONE→FOLD path.
- Latency: acceptance edge E0, fold edges E1..E_N_FOLD. out_valid is high after edge E_N_FOLD (4 edges for the default).
- Throughput: one result per N_FOLD+2 cycles with out_ready held high (6 cycles for the default).
- Arithmetic: XOR only (characteristic 2). No carries.
- Boundary conditions:
  - prod = 0 or prod < x^M: still takes the full N_FOLD cycles; res = prod[M−1:0].
  - rst_n asserted in FOLD or DONE: the operation is discarded and all registers return to reset values immediately.
  - in_valid held high while busy: ignored, no queuing.
  - out_ready high while not in DONE: no effect.

Decomposition:
- Shared package gf233_pkg:
  - constants M, K, PROD_W, FOLD_W, N_FOLD;
  - state enum {IDLE, FOLD, DONE};
  - cnt width $clog2(N_FOLD).
- Sub-module gf233_fold_window: purely combinational. Inputs are acc and window index; output is acc with that window folded. Instantiated once and selected by cnt.
- The FSM, handshake and registers live in the top module.

Test Plan:
- prod = x^233 (bit 233 only), out_ready = 1 → res bits {74, 0} set, all others 0; out_valid high exactly 4 edges after acceptance.
- prod = x^464 → res bits {231, 146, 72} set, from x^464 → x^305 + x^231 → x^231 + x^146 + x^72.
- prod = 0x1234_5678 (below x^233) → res = 0x1234_5678 after 4 fold cycles; in_ready low during E1..E4.
- Random product of two 233-bit operands (OKA_233bit output) vs reference software mod-f reduction, 10k vectors, with random out_ready stalls of 0–7 cycles → all match; res and out_valid stable during stalls.
- Pulse rst_n low in the middle of FOLD (after E2) → out_valid = 0, res = 0, in_ready = 1 after release; the next operand x^233 reduces correctly to {74, 0}.
- Back-to-back: in_valid and out_ready held high → acceptances every 6 cycles; in_valid during FOLD and DONE is ignored.
